// File: rtl/serial_sub4_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional OVF output is enabled with SERIAL_SUB4_OVF_EN.
package serial_sub4_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_sub4_full_sub.sv
// One-bit combinational full subtractor: d = a - b - bin.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor D = A - B, LSB first, valid/ready on both sides.
// Define SERIAL_SUB4_OVF_EN to add the signed-overflow output OVF.
module serial_sub4
   import serial_sub4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB4_OVF_EN
   output logic             BOUT,
   output logic             OVF
`else
   output logic             BOUT
`endif
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] res;
   logic [WIDTH-1:0] res_nxt;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             d_bit;
   logic             br_nxt;
   logic             accept;
   logic             last;

   full_sub u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (br_nxt)
   );

   assign accept  = (state == IDLE) && in_valid;
   assign last    = (state == RUN) && (cnt == LAST);
   assign res_nxt = {d_bit, res};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt       = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) nxt = RUN;
         end
         RUN: begin
            if (cnt == LAST) nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
      end else if (accept) begin
         a_sh <= A;
         b_sh <= B;
         res  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         res  <= res_nxt[WIDTH-1:1];
         cnt  <= cnt + 1'b1;
         br   <= br_nxt;
      end
   end

   // Result registers only move on the final RUN bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         D    <= '0;
         BOUT <= 1'b0;
      end else if (last) begin
         D    <= res_nxt;
         BOUT <= br_nxt;
      end
   end

`ifdef SERIAL_SUB4_OVF_EN
   logic a_msb;
   logic b_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         OVF   <= 1'b0;
      end else begin
         if (accept) begin
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
         end
         if (last) OVF <= (a_msb != b_msb) && (d_bit != a_msb);
      end
   end
`endif

endmodule

// File: doc/serial_sub4.md
# serial_sub4

Bit-serial subtractor computing D = A − B one bit per cycle, LSB first, with a borrow flip-flop. It is the inverse-operation counterpart to the combinational 4-bit adder in the arithmetic exercise set. It sits behind valid/ready handshakes on both sides, so it can be chained with other handshaked arithmetic units in the neuron datapath.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥ 2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands A/B present.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  minuend, unsigned.
- B  in  WIDTH  subtrahend, unsigned.
- out_valid  out  1  result D/BOUT valid.
- out_ready  in  1  consumer accepts result.
- D  out  WIDTH  difference, (A − B) mod 2^WIDTH.
- BOUT  out  1  borrow out; 1 iff A < B (unsigned).
- OVF  out  1  signed overflow. Present only with SERIAL_SUB4_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture A and B into shift registers, clear the borrow flip-flop, set bit counter = 0, go to RUN.
- RUN, one bit per cycle:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift the operand registers right. Shift d into the MSB of the partial-result register. Increment the counter.
  - When counter = WIDTH−1, transfer the final partial result to D and br_next to BOUT (and OVF), then go to DONE.
- DONE:
  - out_valid = 1.
  - Hold D, BOUT and OVF stable until out_valid & out_ready, then go to IDLE.
- in_ready = 0 in RUN and DONE. in_valid is ignored there; no operands are captured or queued.
- D, BOUT and OVF are registered. They keep the last result after the handshake until the next DONE overwrites them. They never change during RUN.
- OVF = (A[MSB] != B[MSB]) & (D[MSB] != A[MSB]), using the captured A and B.
- No acceptance in the same cycle as the output handshake. IDLE is always entered for at least one cycle.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, D 0, BOUT 0, OVF 0. All internal registers are 0.
- Reset asserted in any state, mid-RUN included:
  - Returns immediately (asynchronously) to the reset values.
  - The in-flight operation is discarded with no output.
- Latency: operands accepted at edge k → out_valid rises after edge k+WIDTH. For WIDTH = 4, that is 4 cycles.
- Throughput: at most one operation per WIDTH+2 cycles (accept, WIDTH−1 further RUN cycles, DONE with immediate out_ready, 1 IDLE).
- Back-pressure: DONE persists indefinitely while out_ready = 0, and D is stable throughout.
- out_ready asserted outside DONE has no effect.

## Configuration
- SERIAL_SUB4_OVF_EN defined:
  - OVF port and its flip-flop exist.
  - OVF is computed as above, resets to 0, and is held with D.
- Undefined:
  - No OVF port and no associated logic.
  - All other behaviour is identical.

## Structure
- Package serial_sub4_pkg:
  - state enum typedef (IDLE, RUN, DONE).
  - default WIDTH constant.
  - counter-width constant $clog2(WIDTH).
- One sub-module, full_sub: 1-bit combinational full-subtractor cell (a, b, bin → d, bout). Instantiated once in the RUN datapath.

## Test plan
- WIDTH = 4; A = 9, B = 3, out_ready = 1 → D = 6, BOUT = 0. out_valid exactly 4 cycles after acceptance; in_ready low until the cycle after the output handshake.
- A = 3, B = 9 → D = 0xA, BOUT = 1. Also A = 0, B = 1 → D = 0xF, BOUT = 1. Also A = 0xF, B = 0xF → D = 0, BOUT = 0.
- Back-pressure: A = 7, B = 2 with out_ready low for 5 cycles → out_valid and D = 5 held stable; in_valid pulses with A = 1, B = 1 ignored. After the handshake, the next accepted operation yields its own correct result.
- Reset mid-RUN: assert rst_n = 0 two cycles after accepting A = 0xC, B = 4 → outputs return to reset values immediately; no out_valid is produced afterward.
- With SERIAL_SUB4_OVF_EN: A = 8, B = 1 → D = 7, OVF = 1. A = 5, B = 3 → D = 2, OVF = 0. Without the macro, the same bench (minus the OVF check) passes.
- Exhaustive: all 256 A/B pairs issued back-to-back with out_ready = 1 → every D/BOUT matches (A − B) mod 16 and A < B.
